// File: rtl/coord_stream_feeder.sv
// coord_stream_feeder: buffers one sorted coordinate stream in a small FIFO
// and presents the head coordinate to one leg of a binary merger. An empty,
// starved or finished leg shows an all-ones sentinel so min-selection skips it.
module coord_stream_feeder #(
  parameter int unsigned MERGER_COORD_BITS = 32,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [MERGER_COORD_BITS-1:0] in_coord,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [MERGER_COORD_BITS-1:0] coord_out,
  output logic                         head_valid,
  input  logic                         fetch_next,
  input  logic                         restart,
  output logic                         done,
  output logic                         error
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [MERGER_COORD_BITS-1:0] Sentinel = '1;

  typedef enum logic [1:0] {
    StRun,
    StLastSeen,
    StDone
  } state_e;

  state_e                       state_q, state_d;
  logic [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]              count_q, count_d;
  logic                         error_q, error_d;
  logic [MERGER_COORD_BITS-1:0] mem_q [FIFO_DEPTH];

  logic push, pop;

  // Outputs decoded from registers only; no path from fetch_next/in_valid.
  assign head_valid = (count_q != '0);
  assign in_ready   = (state_q == StRun) && (count_q < DepthCnt);
  assign coord_out  = head_valid ? mem_q[rd_ptr_q] : Sentinel;
  assign done       = (state_q == StDone);
  assign error      = error_q;

  // Handshakes qualify against registered state, so a push into an empty
  // FIFO can never be popped in the same cycle.
  assign push = in_valid && in_ready;
  assign pop  = fetch_next && head_valid;

  // Next-state for pointers, occupancy, stream FSM and sticky error.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;

    // Fetch on an empty leg is a merger bug, except once the stream is done.
    if (fetch_next && !head_valid && (state_q != StDone)) begin
      error_d = 1'b1;
    end
    // The sentinel value is reserved; flag it but keep the beat.
    if (push && (in_coord == Sentinel)) begin
      error_d = 1'b1;
    end

    if (restart) begin
      state_d  = StRun;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase

      unique case (state_q)
        StRun: begin
          if (push && in_last) begin
            state_d = StLastSeen;
          end
        end
        StLastSeen: begin
          if (pop && (count_d == '0)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StRun;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // Storage array; contents are only visible through count, so no reset.
  always_ff @(posedge clock) begin
    if (push && !restart) begin
      mem_q[wr_ptr_q] <= in_coord;
    end
  end

endmodule

// File: tb/tb_coord_stream_feeder.sv
// Directed bench for coord_stream_feeder with hand-computed expectations.
module tb_coord_stream_feeder;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] Ones = 32'hFFFF_FFFF;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_coord;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] coord_out;
  logic         head_valid;
  logic         fetch_next;
  logic         restart;
  logic         done;
  logic         error;

  int n_checks;
  int n_errors;

  coord_stream_feeder #(
    .MERGER_COORD_BITS(W),
    .FIFO_DEPTH       (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_coord  (in_coord),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .coord_out (coord_out),
    .head_valid(head_valid),
    .fetch_next(fetch_next),
    .restart   (restart),
    .done      (done),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before driving/sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, W'(in_ready), 1);
    check_eq({tag, "_coord"}, coord_out, Ones);
    check_eq({tag, "_head_valid"}, W'(head_valid), 0);
    check_eq({tag, "_done"}, W'(done), 0);
    check_eq({tag, "_error"}, W'(error), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_coord   = '0;
    in_last    = 1'b0;
    fetch_next = 1'b0;
    restart    = 1'b0;
    #12;
    check_reset_vals("rst");
    step();
    reset = 1'b1;
    step();

    // Push 3, 7, 9(last), then fetch three times.
    in_valid = 1'b1; in_coord = 32'd3; step();
    check_eq("s1_head3", coord_out, 32'd3);
    in_coord = 32'd7; step();
    check_eq("s1_head_still3", coord_out, 32'd3);
    in_coord = 32'd9; in_last = 1'b1; step();
    check_eq("s1_ready_drop", W'(in_ready), 0);
    in_valid = 1'b0; in_last = 1'b0;
    fetch_next = 1'b1; step();
    check_eq("s1_pop1", coord_out, 32'd7);
    step();
    check_eq("s1_pop2", coord_out, 32'd9);
    check_eq("s1_not_done", W'(done), 0);
    step();
    check_eq("s1_sentinel", coord_out, Ones);
    check_eq("s1_done", W'(done), 1);
    check_eq("s1_err", W'(error), 0);
    step();
    fetch_next = 1'b0;
    check_eq("s1_fetch_in_done_ok", W'(error), 0);
    restart = 1'b1; step(); restart = 1'b0;
    check_eq("s1_restart_done", W'(done), 0);
    check_eq("s1_restart_ready", W'(in_ready), 1);

    // Fill to full, then valid+fetch together: one pop, no push.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_coord = W'(10 + i);
      step();
    end
    check_eq("s2_full_ready", W'(in_ready), 0);
    check_eq("s2_head", coord_out, 32'd10);
    in_coord = 32'd14; fetch_next = 1'b1; step();
    in_valid = 1'b0;
    check_eq("s2_pop_head", coord_out, 32'd11);
    check_eq("s2_ready_back", W'(in_ready), 1);
    step();
    check_eq("s2_drain12", coord_out, 32'd12);
    step();
    check_eq("s2_drain13", coord_out, 32'd13);
    step();
    check_eq("s2_no_push14", coord_out, Ones);
    check_eq("s2_empty", W'(head_valid), 0);
    fetch_next = 1'b0;

    // Streaming 1..20, push and pop every cycle after the first.
    for (int i = 1; i <= 20; i++) begin
      in_valid   = 1'b1;
      in_coord   = W'(i);
      fetch_next = (i > 1);
      step();
      check_eq($sformatf("s3_beat%0d", i), coord_out, W'(i));
    end
    in_valid = 1'b0; fetch_next = 1'b1; step();
    check_eq("s3_drained", coord_out, Ones);
    check_eq("s3_err", W'(error), 0);

    // Fetch on an empty leg in RUN.
    step();
    fetch_next = 1'b0;
    check_eq("s4_err_set", W'(error), 1);
    check_eq("s4_count_zero", W'(head_valid), 0);
    in_valid = 1'b1; in_coord = 32'd5; step(); in_valid = 1'b0;
    check_eq("s4_push_after", coord_out, 32'd5);
    restart = 1'b1; step(); restart = 1'b0;
    check_eq("s4_restart_clear", W'(head_valid), 0);
    check_eq("s4_err_sticky", W'(error), 1);

    // Mid-stream asynchronous reset with two entries buffered.
    in_valid = 1'b1; in_coord = 32'd21; step();
    in_coord = 32'd22; step(); in_valid = 1'b0;
    check_eq("s5_pre_head", coord_out, 32'd21);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("s5_async");
    step();
    reset = 1'b1;
    step();
    in_valid = 1'b1; in_coord = 32'd30; step(); in_valid = 1'b0;
    check_eq("s5_new_head", coord_out, 32'd30);
    fetch_next = 1'b1; step(); fetch_next = 1'b0;
    check_eq("s5_no_stale", coord_out, Ones);
    check_eq("s5_no_stale_hv", W'(head_valid), 0);

    // Reserved all-ones value is flagged but stored.
    in_valid = 1'b1; in_coord = Ones; step(); in_valid = 1'b0;
    check_eq("s6_err", W'(error), 1);
    check_eq("s6_stored", W'(head_valid), 1);
    check_eq("s6_coord", coord_out, Ones);
    fetch_next = 1'b1; step(); fetch_next = 1'b0;
    check_eq("s6_popped", W'(head_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
